// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FETCH/EXECUTE/HALT core, 2 cycles per instruction minimum; fetch stalls until imemValid.
// Define BRANCH_EN to build the JUMPZ zero-compare; without it JUMPZ retires as a NOP.
module multicycle_cpu #(
  parameter int REGISTER_WIDTH      = 8,
  parameter int NUMBER_OF_REGISTERS = 8,
  parameter int PC_WIDTH            = 8
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic                      switch,
  output logic                      imemReq,
  output logic [PC_WIDTH-1:0]       imemAddr,
  input  logic                      imemValid,
  input  logic [31:0]               imemData,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [REGISTER_WIDTH-1:0] register1Value,
  output logic                      halted
);

  localparam int IDX_W = $clog2(NUMBER_OF_REGISTERS);

  localparam logic [5:0] OP_ADD        = 6'd1;
  localparam logic [5:0] OP_LSHIFT     = 6'd2;
  localparam logic [5:0] OP_RSHIFT     = 6'd3;
  localparam logic [5:0] OP_INC        = 6'd4;
  localparam logic [5:0] OP_DEC        = 6'd5;
  localparam logic [5:0] OP_LOAD       = 6'd6;
  localparam logic [5:0] OP_LOADSWITCH = 6'd7;
  localparam logic [5:0] OP_JUMP       = 6'd8;
`ifdef BRANCH_EN
  localparam logic [5:0] OP_JUMPZ      = 6'd9;
`endif
  localparam logic [5:0] OP_HALT       = 6'd10;

  typedef enum logic [1:0] {
    FETCH,
    EXECUTE,
    HALT
  } state_t;

  state_t                    state_q, state_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [31:0]               ir_q, ir_d;
  logic [REGISTER_WIDTH-1:0] regs_q [NUMBER_OF_REGISTERS];
  logic [REGISTER_WIDTH-1:0] regs_d [NUMBER_OF_REGISTERS];

  logic [5:0]                opcode;
  logic [IDX_W-1:0]          r1_idx, r2_idx, out_idx;
  logic [REGISTER_WIDTH-1:0] r1_val, r2_val, imm_dat, wb_dat;
  logic [PC_WIDTH-1:0]       imm_pc, pc_inc;
  logic                      wb_en;
  logic                      unused_ir;

  // Field extraction: casts keep the low index bits and zero-extend/truncate the immediate.
  assign opcode    = ir_q[29:24];
  assign r1_idx    = IDX_W'(ir_q[23:16]);
  assign r2_idx    = IDX_W'(ir_q[15:8]);
  assign out_idx   = IDX_W'(ir_q[7:0]);
  assign imm_dat   = REGISTER_WIDTH'(ir_q[15:8]);
  assign imm_pc    = PC_WIDTH'(ir_q[15:8]);
  assign unused_ir = ^ir_q[31:30];

  assign r1_val = regs_q[r1_idx];
  assign r2_val = regs_q[r2_idx];
  assign pc_inc = pc_q + PC_WIDTH'(1);

`ifdef BRANCH_EN
  logic r1_zero;
  assign r1_zero = (r1_val == '0);
`endif

  always_comb begin
    wb_en  = 1'b0;
    wb_dat = '0;
    case (opcode)
      OP_ADD:        begin wb_en = 1'b1; wb_dat = r1_val + r2_val;                 end
      OP_LSHIFT:     begin wb_en = 1'b1; wb_dat = r1_val << 1;                     end
      OP_RSHIFT:     begin wb_en = 1'b1; wb_dat = r1_val >> 1;                     end
      OP_INC:        begin wb_en = 1'b1; wb_dat = r1_val + REGISTER_WIDTH'(1);     end
      OP_DEC:        begin wb_en = 1'b1; wb_dat = r1_val - REGISTER_WIDTH'(1);     end
      OP_LOAD:       begin wb_en = 1'b1; wb_dat = imm_dat;                         end
      OP_LOADSWITCH: begin wb_en = 1'b1; wb_dat = REGISTER_WIDTH'(switch);         end
      default:       begin wb_en = 1'b0; wb_dat = '0;                              end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    imemReq = 1'b0;
    case (state_q)
      FETCH: begin
        imemReq = 1'b1;
        if (imemValid) begin
          ir_d    = imemData;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_JUMP: pc_d = imm_pc;
`ifdef BRANCH_EN
          OP_JUMPZ: if (r1_zero) pc_d = imm_pc;
`endif
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
          default: ;
        endcase
        // r0 is never written, so it keeps reading zero from reset onward.
        if (wb_en && (out_idx != '0)) regs_d[out_idx] = wb_dat;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
    end
  end

  assign imemAddr       = pc_q;
  assign pc             = pc_q;
  assign register1Value = regs_q[IDX_W'(1)];
  assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboarded random + directed bench for multicycle_cpu; reference model executes
// each fetched instruction with plain integer arithmetic and queues the expected architectural state.
module tb_multicycle_cpu;

  localparam int RW = 8;
  localparam int NR = 8;
  localparam int PW = 8;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] r1;
    logic       halted;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sw;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [7:0]  pc_o;
  logic [7:0]  r1_o;
  logic        halted;

  logic        rst2;
  logic        imem2_req;
  logic [7:0]  imem2_addr;
  logic [31:0] imem2_data;
  logic [7:0]  pc2;
  logic [15:0] r1_2;
  logic        halted2;

  logic [31:0] prog  [256];
  logic [31:0] prog2 [256];

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int   m_reg [NR];
  int   m_pc;
  bit   m_halted;

  multicycle_cpu #(.REGISTER_WIDTH(RW), .NUMBER_OF_REGISTERS(NR), .PC_WIDTH(PW)) dut (
    .clock(clk), .isReset(rst), .switch(sw),
    .imemReq(imem_req), .imemAddr(imem_addr), .imemValid(imem_valid), .imemData(imem_data),
    .pc(pc_o), .register1Value(r1_o), .halted(halted)
  );

  multicycle_cpu #(.REGISTER_WIDTH(16), .NUMBER_OF_REGISTERS(16), .PC_WIDTH(8)) dut16 (
    .clock(clk), .isReset(rst2), .switch(1'b1),
    .imemReq(imem2_req), .imemAddr(imem2_addr), .imemValid(1'b1), .imemData(imem2_data),
    .pc(pc2), .register1Value(r1_2), .halted(halted2)
  );

  assign imem2_data = prog2[imem2_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int a1, input int a2, input int ao);
    return {2'b00, 6'(op), 8'(a1), 8'(a2), 8'(ao)};
  endfunction

  // Reference model: one call per instruction handed to the core.
  function automatic void model_exec(input logic [31:0] w);
    int  op  = int'(w[29:24]);
    int  a1  = int'(w[23:16]) % NR;
    int  a2  = int'(w[15:8]) % NR;
    int  ao  = int'(w[7:0]) % NR;
    int  imm = int'(w[15:8]);
    int  mod = 1 << RW;
    int  npc = (m_pc + 1) % (1 << PW);
    int  res = 0;
    bit  wr  = 1'b1;
    case (op)
      1:  res = m_reg[a1] + m_reg[a2];
      2:  res = m_reg[a1] * 2;
      3:  res = m_reg[a1] / 2;
      4:  res = m_reg[a1] + 1;
      5:  res = m_reg[a1] - 1 + mod;
      6:  res = imm;
      7:  res = int'(sw);
      8:  begin wr = 1'b0; npc = imm % (1 << PW); end
      9:  begin
            wr = 1'b0;
`ifdef BRANCH_EN
            if (m_reg[a1] == 0) npc = imm % (1 << PW);
`endif
          end
      10: begin wr = 1'b0; npc = m_pc; m_halted = 1'b1; end
      default: wr = 1'b0;
    endcase
    if (wr && ao != 0) m_reg[ao] = res % mod;
    m_pc = npc;
    exp_q.push_back('{pc: 8'(m_pc), r1: 8'(m_reg[1]), halted: m_halted});
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    bit         prev_exec = 1'b0;
    bit         started   = 1'b0;
    logic [7:0] cm_pc = '0;
    logic [7:0] cm_r1 = '0;
    logic       cm_h  = 1'b0;
    exp_t       e;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1) begin
        chk("reset_pc", pc_o, 0);
        chk("reset_r1", r1_o, 0);
        chk("reset_halted", halted, 0);
        chk("reset_imem_req", imem_req, 1);
        cm_pc = '0; cm_r1 = '0; cm_h = 1'b0;
        started = 1'b1;
      end else if (started) begin
        if (prev_exec) begin
          if (exp_q.size() == 0) begin
            chk("sb_retire_expected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            cm_pc = e.pc; cm_r1 = e.r1; cm_h = e.halted;
          end
        end
        chk("pc", pc_o, cm_pc);
        chk("r1", r1_o, cm_r1);
        chk("halted", halted, cm_h);
        chk("imem_addr", imem_addr, cm_pc);
      end
      prev_exec = started && (imem_req === 1'b0) && (halted === 1'b0);
    end
  end

  task automatic do_reset(input bit sw_val);
    rst        = 1'b1;
    sw         = sw_val;
    imem_valid = 1'b1;
    imem_data  = $urandom;
    exp_q.delete();
    m_pc     = 0;
    m_halted = 1'b0;
    foreach (m_reg[i]) m_reg[i] = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run(input int pct, input int ncyc, output int halt_cyc);
    halt_cyc = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (imem_req === 1'b1) begin
        if (!m_halted && int'($urandom_range(99)) < pct) begin
          imem_valid = 1'b1;
          imem_data  = prog[imem_addr];
          model_exec(prog[m_pc]);
        end else begin
          imem_valid = 1'b0;
          imem_data  = $urandom;
        end
      end else begin
        imem_valid = 1'($urandom_range(1));
        imem_data  = $urandom;
      end
      @(posedge clk);
      #2;
      if (halted === 1'b1 && halt_cyc < 0) halt_cyc = k + 1;
    end
    imem_valid = 1'b0;
    chk("sb_drain", 32'(exp_q.size() <= 1), 1);
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = '0;
  endtask

  task automatic gen_prog();
    int op;
    foreach (prog[i]) begin
      if ($urandom_range(99) < 5)       op = 10;
      else if ($urandom_range(99) < 8)  op = int'($urandom_range(63, 11));
      else                              op = int'($urandom_range(9));
      prog[i] = {2'($urandom_range(3)), 6'(op), 8'($urandom), 8'($urandom), 8'($urandom)};
    end
  endtask

  initial begin
    int hc;
    rst = 1'b1; rst2 = 1'b1; sw = 1'b0; imem_valid = 1'b0; imem_data = '0;
    foreach (prog2[i]) prog2[i] = '0;
    prog2[0] = ins(7, 0, 0, 9);
    prog2[1] = ins(1, 9, 9, 1);
    prog2[2] = ins(10, 0, 0, 0);

    // LOAD r1,5; INC r1; HALT with zero-wait memory.
    clear_prog();
    prog[0] = ins(6, 0, 5, 1);
    prog[1] = ins(4, 1, 0, 1);
    prog[2] = ins(10, 0, 0, 0);
    do_reset(1'b0);
    run(100, 10, hc);
    chk("halt_latency", hc, 6);
    chk("basic_r1", r1_o, 6);
    chk("basic_pc", pc_o, 2);

    // Wraparound arithmetic and r0 immutability, with wait states.
    clear_prog();
    prog[0] = ins(6, 0, 'hFF, 1);
    prog[1] = ins(4, 1, 0, 1);
    prog[2] = ins(6, 0, 'h80, 1);
    prog[3] = ins(2, 1, 0, 1);
    prog[4] = ins(6, 0, 7, 0);
    prog[5] = ins(6, 0, 3, 2);
    prog[6] = ins(1, 0, 2, 1);
    prog[7] = ins(5, 0, 0, 3);
    prog[8] = ins(10, 0, 0, 0);
    do_reset(1'b0);
    run(40, 80, hc);
    chk("wrap_r1_final", r1_o, 3);
    chk("wrap_halted", halted, 1);

    // pc wrap through NOP at 0xFF.
    clear_prog();
    prog[0] = ins(8, 0, 'hFF, 0);
    do_reset(1'b0);
    run(100, 12, hc);

    // JUMPZ at 0xFF with r1 == 0.
    clear_prog();
    prog[0]    = ins(8, 0, 'hFF, 0);
    prog[255]  = ins(9, 1, 'h20, 0);
    prog['h20] = ins(10, 0, 0, 0);
    do_reset(1'b0);
    run(100, 12, hc);
`ifdef BRANCH_EN
    chk("jumpz_halted", halted, 1);
    chk("jumpz_pc", pc_o, 'h20);
`else
    chk("jumpz_halted", halted, 0);
`endif

    // Reset lands on the EXECUTE cycle of LOAD r1,9.
    clear_prog();
    prog[0] = ins(6, 0, 9, 1);
    do_reset(1'b0);
    run(100, 1, hc);
    do_reset(1'b0);
    chk("rst_exec_r1", r1_o, 0);
    chk("rst_exec_pc", pc_o, 0);
    chk("rst_exec_fetch", imem_req, 1);

    // Random programs, random wait states, resets at arbitrary points.
    for (int e = 0; e < 40; e++) begin
      gen_prog();
      do_reset(1'($urandom_range(1)));
      run(int'($urandom_range(100, 20)), int'($urandom_range(200, 20)), hc);
    end

    // Wide instance: LOADSWITCH r9; ADD r1 = r9 + r9; HALT.
    rst2 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (halted2 === 1'b1) break;
    end
    chk("w16_halted", halted2, 1);
    chk("w16_r1", r1_2, 32'h0002);
    chk("w16_pc", pc2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
